// File: rtl/e15_pkg.sv
// rtl/e15_pkg.sv - shared E15 encodings, instruction fields and decode helpers
package e15_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_HALT = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        CMD_RUN   = 2'b00,
        CMD_STEP  = 2'b01,
        CMD_STOP  = 2'b10,
        CMD_CLEAR = 2'b11
    } cmd_op_t;

    typedef enum logic [2:0] {
        RSN_NONE      = 3'd0,
        RSN_USER      = 3'd1,
        RSN_BREAK     = 3'd2,
        RSN_SELF_LOOP = 3'd3,
        RSN_TIMEOUT   = 3'd4
    } stop_reason_t;

    localparam logic [3:0] OP_JMP = 4'b0000;

    localparam int OPC_MSB = 11;
    localparam int OPC_LSB = 8;
    localparam int SRC_MSB = 7;
    localparam int SRC_LSB = 6;
    localparam int DST_MSB = 5;
    localparam int DST_LSB = 4;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

    // A jmp with target 0 is treated as "jump to self": the program has parked.
    function automatic logic is_self_loop(input logic [11:0] instr);
        return (instr[OPC_MSB:OPC_LSB] == OP_JMP) && (instr[IMM_MSB:IMM_LSB] == 4'd0);
    endfunction

endpackage

// File: rtl/e15_sat_counter.sv
// rtl/e15_sat_counter.sv - saturating up-counter with enable and synchronous clear
module e15_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/e15_run_ctrl.sv
// rtl/e15_run_ctrl.sv - run/step/stop controller gating a small processor
module e15_run_ctrl
    import e15_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int MAX_CYCLES = 200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    output logic             cmd_ready,
    input  logic             bp_en,
    input  logic [3:0]       bp_addr,
    input  logic [3:0]       pc_in,
    input  logic [11:0]      instr_in,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic [2:0]       stop_reason,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CYCLES);

    state_t       state_q, state_nxt;
    stop_reason_t reason_q, reason_nxt;
    logic         bp_skip_q, bp_skip_nxt;
    logic         cpu_en_raw;
    logic         cnt_clr;
    logic         cmd_acc;
    logic         self_loop, timeout, bp_hit;

    assign cmd_ready = (state_q != ST_STEP);
    assign cmd_acc   = cmd_valid && cmd_ready;
    assign self_loop = is_self_loop(instr_in);
    assign timeout   = (cycle_cnt >= MAX_CNT);
    assign bp_hit    = bp_en && (pc_in == bp_addr) && !bp_skip_q;

    always_comb begin
        state_nxt   = state_q;
        reason_nxt  = reason_q;
        bp_skip_nxt = bp_skip_q;
        cpu_en_raw  = 1'b0;
        cnt_clr     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_acc) begin
                    unique case (cmd_op_t'(cmd_op))
                        CMD_RUN: begin
                            // Budget already spent: park in HALT without issuing a cycle.
                            if (timeout) begin
                                state_nxt  = ST_HALT;
                                reason_nxt = RSN_TIMEOUT;
                            end else begin
                                state_nxt   = ST_RUN;
                                reason_nxt  = RSN_NONE;
                                bp_skip_nxt = 1'b1;
                            end
                        end
                        CMD_STEP: begin
                            state_nxt   = ST_STEP;
                            bp_skip_nxt = 1'b1;
                        end
                        CMD_CLEAR: begin
                            cnt_clr    = 1'b1;
                            reason_nxt = RSN_NONE;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (self_loop) begin
                    state_nxt  = ST_HALT;
                    reason_nxt = RSN_SELF_LOOP;
                end else if (timeout) begin
                    state_nxt  = ST_HALT;
                    reason_nxt = RSN_TIMEOUT;
                end else if (bp_hit) begin
                    state_nxt  = ST_IDLE;
                    reason_nxt = RSN_BREAK;
                end else if (cmd_acc && (cmd_op_t'(cmd_op) == CMD_STOP)) begin
                    state_nxt  = ST_IDLE;
                    reason_nxt = RSN_USER;
                end else begin
                    cpu_en_raw  = 1'b1;
                    bp_skip_nxt = 1'b0;
                end
            end
            ST_STEP: begin
                cpu_en_raw  = 1'b1;
                bp_skip_nxt = 1'b0;
                state_nxt   = ST_IDLE;
            end
            ST_HALT: begin
                if (cmd_acc && (cmd_op_t'(cmd_op) == CMD_CLEAR)) begin
                    state_nxt  = ST_IDLE;
                    reason_nxt = RSN_NONE;
                    cnt_clr    = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            reason_q  <= RSN_NONE;
            bp_skip_q <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            reason_q  <= reason_nxt;
            bp_skip_q <= bp_skip_nxt;
        end
    end

    assign cpu_en      = cpu_en_raw && !reset;
    assign state       = state_q;
    assign stop_reason = reason_q;

    e15_sat_counter #(
        .W(CNT_W)
    ) u_cycle_cnt (
        .clk (clk),
        .clr (reset || cnt_clr),
        .en  (cpu_en),
        .q   (cycle_cnt)
    );

endmodule

// File: tb/tb_e15_run_ctrl.sv
// tb/tb_e15_run_ctrl.sv - self-checking bench for e15_run_ctrl with executed-PC scoreboard
module tb_e15_run_ctrl;
    import e15_pkg::*;

    localparam int CNT_W      = 4;
    localparam int MAX_CYCLES = 10;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic [1:0]       cmd_op = 2'b00;
    logic             cmd_ready;
    logic             bp_en = 1'b0;
    logic [3:0]       bp_addr = 4'd0;
    logic [3:0]       pc_in;
    logic [11:0]      instr_in;
    logic             cpu_en;
    logic [1:0]       state;
    logic [2:0]       stop_reason;
    logic [CNT_W-1:0] cycle_cnt;

    logic [11:0] mem [16];
    logic [3:0]  pc = 4'd0;
    int          exp_q [$];
    int          n_tests = 0;
    int          n_fail = 0;

    e15_run_ctrl #(
        .CNT_W      (CNT_W),
        .MAX_CYCLES (MAX_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_op      (cmd_op),
        .cmd_ready   (cmd_ready),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .pc_in       (pc_in),
        .instr_in    (instr_in),
        .cpu_en      (cpu_en),
        .state       (state),
        .stop_reason (stop_reason),
        .cycle_cnt   (cycle_cnt)
    );

    always #5 clk = ~clk;

    // Tiny processor model: jmp loads imm into PC, everything else falls through.
    assign pc_in    = pc;
    assign instr_in = mem[pc];
    always @(posedge clk) begin
        if (reset) pc <= 4'd0;
        else if (cpu_en) pc <= (mem[pc][11:8] == 4'd0) ? mem[pc][3:0] : pc + 4'd1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cpu_en) begin
            if (exp_q.size() == 0) check("sb_unexpected_cpu_en", exp_q.size(), 1);
            else check("sb_pc", int'(pc_in), exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1 check("rst_cpu_en", int'(cpu_en), 0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic load_nop();
        for (int i = 0; i < 16; i++) mem[i] = 12'h100;
    endtask

    task automatic send(input logic [1:0] op);
        cmd_valid = 1'b1;
        cmd_op    = op;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) exp_q.push_back(i % 16);
    endtask

    task automatic wait_state(input string tag, input int s, input int budget);
        int n = 0;
        while (int'(state) != s && n < budget) begin
            tick();
            n++;
        end
        check(tag, int'(state), s);
    endtask

    task automatic wait_pc(input string tag, input int p, input int budget);
        int n = 0;
        while (int'(pc_in) != p && n < budget) begin
            tick();
            n++;
        end
        check(tag, int'(pc_in), p);
    endtask

    task automatic step_once();
        cmd_valid = 1'b1;
        cmd_op    = CMD_STEP;
        tick();
        cmd_valid = 1'b0;
        #1;
        check("step_ready", int'(cmd_ready), 0);
        check("step_cpu_en", int'(cpu_en), 1);
        tick();
        check("step_back_idle", int'(state), int'(ST_IDLE));
    endtask

    initial begin
        // reset state
        load_nop();
        mem[5] = 12'h000;
        do_reset();
        check("rst_state", int'(state), int'(ST_IDLE));
        check("rst_reason", int'(stop_reason), 0);
        check("rst_cnt", int'(cycle_cnt), 0);
        check("rst_ready", int'(cmd_ready), 1);

        // run into self-loop at PC 5
        push_range(0, 4);
        send(CMD_RUN);
        check("run_state", int'(state), int'(ST_RUN));
        wait_state("sl_halt", int'(ST_HALT), 30);
        check("sl_reason", int'(stop_reason), int'(RSN_SELF_LOOP));
        check("sl_cnt", int'(cycle_cnt), 5);
        check("sl_cpu_en", int'(cpu_en), 0);
        check("sl_q", exp_q.size(), 0);

        // breakpoint at PC 3, then resume over it
        do_reset();
        bp_en = 1'b1;
        bp_addr = 4'd3;
        push_range(0, 2);
        send(CMD_RUN);
        wait_state("bp_idle", int'(ST_IDLE), 30);
        check("bp_reason", int'(stop_reason), int'(RSN_BREAK));
        check("bp_cnt", int'(cycle_cnt), 3);
        check("bp_cpu_en", int'(cpu_en), 0);
        push_range(3, 4);
        send(CMD_RUN);
        check("bp_rerun_reason", int'(stop_reason), int'(RSN_NONE));
        check("bp_rerun_cpu_en", int'(cpu_en), 1);
        wait_state("bp_halt", int'(ST_HALT), 30);
        check("bp_resume_cnt", int'(cycle_cnt), 5);
        check("bp_q", exp_q.size(), 0);
        bp_en = 1'b0;

        // two-instruction loop hits the watchdog
        load_nop();
        mem[2] = 12'h001;
        do_reset();
        exp_q = '{0, 1, 2, 1, 2, 1, 2, 1, 2, 1};
        send(CMD_RUN);
        wait_state("to_halt", int'(ST_HALT), 40);
        check("to_reason", int'(stop_reason), int'(RSN_TIMEOUT));
        check("to_cnt", int'(cycle_cnt), 10);
        check("to_q", exp_q.size(), 0);
        send(CMD_RUN);
        tick();
        check("to_run_ignored", int'(state), int'(ST_HALT));
        send(CMD_CLEAR);
        check("to_clear_state", int'(state), int'(ST_IDLE));
        check("to_clear_cnt", int'(cycle_cnt), 0);
        check("to_clear_reason", int'(stop_reason), 0);

        // single steps, saturation, RUN past budget, step on self-loop
        load_nop();
        do_reset();
        push_range(0, 2);
        for (int i = 0; i < 3; i++) step_once();
        check("step3_cnt", int'(cycle_cnt), 3);
        check("step3_reason", int'(stop_reason), 0);
        push_range(3, 16);
        for (int i = 0; i < 14; i++) step_once();
        check("sat_cnt", int'(cycle_cnt), 15);
        check("sat_q", exp_q.size(), 0);
        send(CMD_RUN);
        check("late_run_state", int'(state), int'(ST_HALT));
        check("late_run_reason", int'(stop_reason), int'(RSN_TIMEOUT));
        tick();
        check("late_run_cnt", int'(cycle_cnt), 15);
        send(CMD_CLEAR);
        check("late_clear_cnt", int'(cycle_cnt), 0);
        mem[1] = 12'h000;
        exp_q.push_back(1);
        step_once();
        check("step_sl_cnt", int'(cycle_cnt), 1);
        check("step_sl_q", exp_q.size(), 0);

        // STOP coinciding with self-loop loses on priority
        load_nop();
        mem[5] = 12'h000;
        do_reset();
        push_range(0, 4);
        send(CMD_RUN);
        wait_pc("prio_pc", 5, 20);
        cmd_valid = 1'b1;
        cmd_op = CMD_STOP;
        #1 check("prio_cpu_en", int'(cpu_en), 0);
        tick();
        cmd_valid = 1'b0;
        check("prio_state", int'(state), int'(ST_HALT));
        check("prio_reason", int'(stop_reason), int'(RSN_SELF_LOOP));

        // user STOP on an ordinary instruction
        do_reset();
        push_range(0, 1);
        send(CMD_RUN);
        wait_pc("stop_pc", 2, 20);
        cmd_valid = 1'b1;
        cmd_op = CMD_STOP;
        #1 check("stop_cpu_en", int'(cpu_en), 0);
        tick();
        cmd_valid = 1'b0;
        check("stop_state", int'(state), int'(ST_IDLE));
        check("stop_reason", int'(stop_reason), int'(RSN_USER));
        check("stop_cnt", int'(cycle_cnt), 2);

        // reset during the 4th RUN cycle
        do_reset();
        push_range(0, 2);
        send(CMD_RUN);
        tick();
        tick();
        tick();
        reset = 1'b1;
        #1 check("mid_rst_cpu_en", int'(cpu_en), 0);
        tick();
        reset = 1'b0;
        check("mid_rst_state", int'(state), 0);
        check("mid_rst_reason", int'(stop_reason), 0);
        check("mid_rst_cnt", int'(cycle_cnt), 0);
        check("mid_rst_q", exp_q.size(), 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_tests);
        $fatal(1);
    end

endmodule

// File: doc/e15_run_ctrl.md
E15_RUN_CTRL -- requirements
Module: e15_run_ctrl

Interface
REQ-001 The block SHALL provide parameter CNT_W, default 8, setting the cycle-counter width.
REQ-002 The block SHALL provide parameter MAX_CYCLES, default 200, setting the RUN watchdog limit (1..2^CNT_W-1).
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_op  input  2  command: 00 RUN, 01 STEP, 10 STOP, 11 CLEAR.
REQ-007 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-008 bp_en  input  1  breakpoint enable.
REQ-009 bp_addr  input  4  breakpoint PC.
REQ-010 pc_in  input  4  processor PC.
REQ-011 instr_in  input  12  instruction at pc_in: opcode[11:8], src[7:6], dst[5:4], imm[3:0].
REQ-012 cpu_en  output  1  processor advances one instruction on this edge.
REQ-013 state  output  2  00 IDLE, 01 RUN, 10 STEP, 11 HALT.
REQ-014 stop_reason  output  3  0 NONE, 1 USER, 2 BREAK, 3 SELF_LOOP, 4 TIMEOUT.
REQ-015 cycle_cnt  output  CNT_W  count of cpu_en cycles since the last reset or CLEAR.

Function
REQ-016 cmd_ready SHALL be 1 in every state except STEP.
REQ-017 A command that is illegal in the current state SHALL be accepted and ignored.
REQ-018 IDLE: RUN -> RUN; STEP -> STEP; CLEAR zeroes cycle_cnt and stop_reason; STOP is ignored.
REQ-019 RUN: cpu_en SHALL be 1 unless a stop condition holds in the same cycle, in which case cpu_en = 0.
REQ-020 Stop conditions in RUN, highest priority first:
- self-loop: instr_in = jmp (0000) with imm = 0 -> HALT, reason SELF_LOOP;
- timeout: cycle_cnt = MAX_CYCLES -> HALT, reason TIMEOUT;
- breakpoint: bp_en && pc_in = bp_addr && !bp_skip -> IDLE, reason BREAK;
- accepted STOP -> IDLE, reason USER.
REQ-021 STEP: cpu_en SHALL be 1 for exactly one cycle, after which state returns to IDLE with stop_reason unchanged.
REQ-022 STEP on a self-loop instruction SHALL still execute exactly one cycle.
REQ-023 bp_skip SHALL be set when RUN or STEP is entered and cleared after the first cpu_en cycle, so that execution can resume from a breakpoint PC.
REQ-024 HALT: cpu_en = 0; only CLEAR (-> IDLE, cycle_cnt = 0, reason NONE) or reset SHALL exit it.
REQ-025 cycle_cnt SHALL increment by 1 on every cycle with cpu_en = 1 and saturate at 2^CNT_W-1, with no wrap-around.
REQ-026 Entering RUN SHALL NOT clear cycle_cnt; the count accumulates across RUN and STEP.
REQ-027 stop_reason SHALL hold until the next stop event or CLEAR, and SHALL be set to NONE when RUN is accepted.
REQ-028 If RUN is accepted while cycle_cnt >= MAX_CYCLES, the block SHALL enter HALT with reason TIMEOUT on the next cycle and SHALL assert cpu_en for zero cycles.
REQ-029 cpu_en SHALL be combinational from registered state, pc_in, instr_in, cmd and bp inputs; all other outputs SHALL be registered.

Reset
REQ-030 While reset = 1, cpu_en SHALL be 0 in the same cycle.
REQ-031 On the first posedge with reset = 1: state = IDLE, stop_reason = NONE, cycle_cnt = 0, bp_skip = 0.
REQ-032 Reset asserted mid-RUN or mid-STEP SHALL abort immediately, with no further cpu_en pulse.

Structure
REQ-033 A shared package e15_pkg SHALL hold the E15 opcode constants, the state, cmd_op and stop_reason encodings, and the instruction field positions.
REQ-034 One sub-module, e15_sat_counter (CNT_W wide, with enable, clear and saturate), SHALL implement cycle_cnt.

Verification
REQ-035 Reset, then RUN with a program whose instruction at PC 5 is jmp imm 0 -> cpu_en high for 5 cycles, state = HALT, reason = 3, cycle_cnt = 5.
REQ-036 bp_en = 1, bp_addr = 3, RUN -> stop at pc_in = 3 with reason = 2, state = IDLE, cpu_en = 0; then RUN -> PC 3 executes (bp_skip), cycle_cnt increments.
REQ-037 MAX_CYCLES = 10, infinite two-instruction loop, RUN -> exactly 10 cpu_en pulses, then HALT, reason = 4; a subsequent RUN is ignored; CLEAR -> IDLE, cycle_cnt = 0.
REQ-038 STEP issued three times from IDLE -> three single-cycle cpu_en pulses; cmd_ready = 0 during each STEP cycle; cycle_cnt = 3.
REQ-039 STOP issued in the same cycle the self-loop instruction is presented -> HALT with reason 3 (priority rule); STOP during RUN on an ordinary instruction -> IDLE with reason 1 and cpu_en = 0 in that cycle.
REQ-040 reset asserted during the 4th RUN cycle -> cpu_en = 0 immediately; next cycle state = 0, reason = 0, cycle_cnt = 0.
